// File: rtl/epp_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : epp_clk_gen
//  Description : Counter-based clock generator for the EPD/EPP panel driver.
//                Produces two integer-divided clocks from the differential
//                reference, plus a lock flag that doubles as downstream
//                run / active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module epp_clk_gen #(
    parameter int CLK1_DIV    = 2,
    parameter int CLK2_DIV    = 6,
    parameter int LOCK_CYCLES = 1024,
    parameter int FAULT_LIMIT = 4
) (
    input  logic clk_in1_p,
    input  logic resetn,
    input  logic clk_in1_n,
    output logic clk_out1,
    output logic clk_out2,
    output logic locked
);

    localparam int C1_W = (CLK1_DIV > 2) ? $clog2(CLK1_DIV) : 1;
    localparam int C2_W = (CLK2_DIV > 2) ? $clog2(CLK2_DIV) : 1;
    localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;
    localparam int FC_W = (FAULT_LIMIT > 1) ? $clog2(FAULT_LIMIT + 1) : 1;

    localparam logic [C1_W-1:0] C1_LAST  = C1_W'(CLK1_DIV - 1);
    localparam logic [C1_W-1:0] C1_HALF  = C1_W'(CLK1_DIV / 2);
    localparam logic [C2_W-1:0] C2_LAST  = C2_W'(CLK2_DIV - 1);
    localparam logic [C2_W-1:0] C2_HALF  = C2_W'(CLK2_DIV / 2);
    localparam logic [LK_W-1:0] LOCK_MAX  = LK_W'(LOCK_CYCLES);
    localparam logic [FC_W-1:0] FAULT_MAX = FC_W'(FAULT_LIMIT);

    logic [C1_W-1:0] c1_q, c1_d;
    logic [C2_W-1:0] c2_q, c2_d;
    logic            clk1_q, clk1_d;
    logic            clk2_q, clk2_d;
    logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [FC_W-1:0] fault_cnt_q, fault_cnt_d;
    logic            locked_q, locked_d;
    logic            fault_w;

    always_comb begin
        c1_d   = (c1_q == C1_LAST) ? '0 : c1_q + 1'b1;
        c2_d   = (c2_q == C2_LAST) ? '0 : c2_q + 1'b1;
        clk1_d = (c1_q < C1_HALF);
        clk2_d = (c2_q < C2_HALF);

        // The negative leg must be low at every rising edge of the positive leg.
        if (clk_in1_n) begin
            fault_cnt_d = (fault_cnt_q == FAULT_MAX) ? fault_cnt_q : fault_cnt_q + 1'b1;
        end else begin
            fault_cnt_d = '0;
        end
        fault_w = (fault_cnt_d == FAULT_MAX);

        // A fault on the edge that would complete the lock count still wins.
        if (fault_w) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
            locked_d   = locked_q | (lock_cnt_d == LOCK_MAX);
        end
    end

    always_ff @(posedge clk_in1_p or negedge resetn) begin
        if (!resetn) begin
            c1_q        <= '0;
            c2_q        <= '0;
            clk1_q      <= 1'b0;
            clk2_q      <= 1'b0;
            lock_cnt_q  <= '0;
            fault_cnt_q <= '0;
            locked_q    <= 1'b0;
        end else begin
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            clk1_q      <= clk1_d;
            clk2_q      <= clk2_d;
            lock_cnt_q  <= lock_cnt_d;
            fault_cnt_q <= fault_cnt_d;
            locked_q    <= locked_d;
        end
    end

    assign clk_out1 = clk1_q;
    assign clk_out2 = clk2_q;
    assign locked   = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_epp_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_epp_clk_gen
//  Description : Directed self-checking bench for epp_clk_gen (default build
//                plus a CLK2_DIV=5 / LOCK_CYCLES=4 build on the same inputs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_epp_clk_gen;

    localparam int LOCK = 1024;

    logic clk_in1_p = 1'b0;
    logic clk_in1_n = 1'b1;
    logic resetn    = 1'b0;
    logic force_n   = 1'b0;

    logic out1, out2, lck;
    logic u5_out1, u5_out2, u5_lck;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;
    int since    = 0;

    epp_clk_gen u_dut (
        .clk_in1_p (clk_in1_p),
        .resetn    (resetn),
        .clk_in1_n (clk_in1_n),
        .clk_out1  (out1),
        .clk_out2  (out2),
        .locked    (lck)
    );

    epp_clk_gen #(
        .CLK2_DIV    (5),
        .LOCK_CYCLES (4)
    ) u_dut5 (
        .clk_in1_p (clk_in1_p),
        .resetn    (resetn),
        .clk_in1_n (clk_in1_n),
        .clk_out1  (u5_out1),
        .clk_out2  (u5_out2),
        .locked    (u5_lck)
    );

    // n leads p slightly so each rising edge of p sees a settled n;
    // force_n holds n high across the edge to emulate a bad differential.
    always begin
        #4 clk_in1_n = force_n;
        #1 clk_in1_p = 1'b1;
        #4 clk_in1_n = 1'b1;
        #1 clk_in1_p = 1'b0;
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, k, act, exp);
        end
    endtask

    // One rising edge; divider phases are checked against the edge count k.
    task automatic step(input bit bad, input bit exp_l, input bit exp_l5);
        force_n = bad;
        @(posedge clk_in1_p);
        #1;
        k++;
        check_eq("clk_out1",    out1,    int'(((k - 1) % 2) < 1));
        check_eq("clk_out2",    out2,    int'(((k - 1) % 6) < 3));
        check_eq("locked",      lck,     int'(exp_l));
        check_eq("d5_clk_out1", u5_out1, int'(((k - 1) % 2) < 1));
        check_eq("d5_clk_out2", u5_out2, int'(((k - 1) % 5) < 2));
        check_eq("d5_locked",   u5_lck,  int'(exp_l5));
    endtask

    task automatic run_clean(input int n);
        for (int i = 0; i < n; i++) begin
            since++;
            step(1'b0, since >= LOCK, since >= 4);
        end
    endtask

    initial begin
        int guard;

        repeat (3) @(posedge clk_in1_p);
        #1;
        check_eq("rst_clk_out1", out1, 0);
        check_eq("rst_clk_out2", out2, 0);
        check_eq("rst_locked",   lck,  0);
        check_eq("rst_d5_out2",  u5_out2, 0);

        // Release between edges; lock must rise exactly on edge LOCK.
        #1 resetn = 1'b1;
        k = 0; since = 0;
        run_clean(1100);

        run_clean(10000);

        // Two 3-edge glitches separated by one good edge: no loss of lock.
        repeat (3) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);

        // Four consecutive bad edges: lock drops on the fourth.
        repeat (3) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        since = 0;
        run_clean(1030);

        // Async reset while clk_out2 is high, between edges.
        guard = 0;
        while (out2 !== 1'b1 && guard < 8) begin
            run_clean(1);
            guard++;
        end
        check_eq("wait_clk_out2_high", out2, 1);
        #2 resetn = 1'b0;
        #1;
        check_eq("async_clk_out1", out1,    0);
        check_eq("async_clk_out2", out2,    0);
        check_eq("async_locked",   lck,     0);
        check_eq("async_d5_out2",  u5_out2, 0);
        check_eq("async_d5_lock",  u5_lck,  0);
        @(posedge clk_in1_p);
        #2 resetn = 1'b1;
        k = 0; since = 0;
        run_clean(1030);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
